// File: rtl/adam_axil_ram_mp.sv
// Multi-port AXI-Lite scratchpad RAM: NUM_PORTS slaves share one byte-writable array through
// a round-robin arbiter, with a 1- or 2-cycle read return, DECERR past SIZE and a pause/drain handshake.
module adam_axil_ram_mp #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE         = 4096,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int WORDS        = SIZE / STRB_WIDTH
) (
  input  logic                                   seq_clk,
  input  logic                                   seq_rst,
  input  logic                                   pause_req,
  output logic                                   pause_ack,
  input  logic [NUM_PORTS-1:0]                   slv_aw_valid,
  output logic [NUM_PORTS-1:0]                   slv_aw_ready,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   slv_aw_addr,
  input  logic [NUM_PORTS-1:0]                   slv_w_valid,
  output logic [NUM_PORTS-1:0]                   slv_w_ready,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   slv_w_data,
  input  logic [NUM_PORTS-1:0][STRB_WIDTH-1:0]   slv_w_strb,
  output logic [NUM_PORTS-1:0]                   slv_b_valid,
  input  logic [NUM_PORTS-1:0]                   slv_b_ready,
  output logic [NUM_PORTS-1:0][1:0]              slv_b_resp,
  input  logic [NUM_PORTS-1:0]                   slv_ar_valid,
  output logic [NUM_PORTS-1:0]                   slv_ar_ready,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   slv_ar_addr,
  output logic [NUM_PORTS-1:0]                   slv_r_valid,
  input  logic [NUM_PORTS-1:0]                   slv_r_ready,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   slv_r_data,
  output logic [NUM_PORTS-1:0][1:0]              slv_r_resp
);

  localparam int OFF = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int IW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [PW-1:0]         rr_ptr;
  logic [NUM_PORTS-1:0]  wr_elig, rd_elig, req, rd_pend;
  logic                  gnt_valid, gnt_wr, gnt_rd;
  logic [PW-1:0]         gnt_port;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_ok;
  logic [IW-1:0]         acc_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  ret_valid;
  logic [PW-1:0]         ret_port;
  logic [DATA_WIDTH-1:0] ret_data;
  logic [1:0]            ret_resp;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_elig[p] = slv_aw_valid[p] && slv_w_valid[p] && (!slv_b_valid[p] || slv_b_ready[p]);
      rd_elig[p] = slv_ar_valid[p] && !rd_pend[p] && (!slv_r_valid[p] || slv_r_ready[p]);
    end
    req = (wr_elig | rd_elig) & {NUM_PORTS{seq_rst && !pause_req}};
  end

  // Scan downward so the eligible port closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    int j;
    gnt_valid = 1'b0;
    gnt_port  = '0;
    j         = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % NUM_PORTS;
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_port  = PW'(j);
      end
    end
  end

  always_comb begin
    gnt_wr   = gnt_valid && wr_elig[gnt_port];
    gnt_rd   = gnt_valid && !wr_elig[gnt_port];
    acc_addr = gnt_wr ? slv_aw_addr[gnt_port] : slv_ar_addr[gnt_port];
    acc_ok   = {1'b0, acc_addr} < (ADDR_WIDTH + 1)'(SIZE);
    acc_idx  = acc_addr[OFF +: IW];
    rd_word  = acc_ok ? mem[acc_idx] : '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      slv_aw_ready[p] = gnt_wr && (gnt_port == PW'(p));
      slv_w_ready[p]  = gnt_wr && (gnt_port == PW'(p));
      slv_ar_ready[p] = gnt_rd && (gnt_port == PW'(p));
    end
  end

  always_ff @(posedge seq_clk) begin
    if (gnt_wr && acc_ok) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (slv_w_strb[gnt_port][b]) mem[acc_idx][8*b +: 8] <= slv_w_data[gnt_port][8*b +: 8];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // Output-register stage; the port stays blocked for reads while its access sits here.
      logic                  stg_valid;
      logic [PW-1:0]         stg_port;
      logic [DATA_WIDTH-1:0] stg_data;
      logic [1:0]            stg_resp;

      always_ff @(posedge seq_clk) begin
        if (!seq_rst) begin
          stg_valid <= 1'b0;
          stg_port  <= '0;
          stg_data  <= '0;
          stg_resp  <= RESP_OKAY;
        end else begin
          stg_valid <= gnt_rd;
          stg_port  <= gnt_port;
          stg_data  <= rd_word;
          stg_resp  <= acc_ok ? RESP_OKAY : RESP_DECERR;
        end
      end

      always_comb begin
        rd_pend = '0;
        for (int p = 0; p < NUM_PORTS; p++) rd_pend[p] = stg_valid && (stg_port == PW'(p));
      end

      assign ret_valid = stg_valid;
      assign ret_port  = stg_port;
      assign ret_data  = stg_data;
      assign ret_resp  = stg_resp;
    end else begin : g_lat1
      assign rd_pend   = '0;
      assign ret_valid = gnt_rd;
      assign ret_port  = gnt_port;
      assign ret_data  = rd_word;
      assign ret_resp  = acc_ok ? RESP_OKAY : RESP_DECERR;
    end
  endgenerate

  always_ff @(posedge seq_clk) begin
    if (!seq_rst) begin
      slv_b_valid <= '0;
      slv_b_resp  <= '0;
      slv_r_valid <= '0;
      slv_r_data  <= '0;
      slv_r_resp  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt_wr && (gnt_port == PW'(p))) begin
          slv_b_valid[p] <= 1'b1;
          slv_b_resp[p]  <= acc_ok ? RESP_OKAY : RESP_DECERR;
        end else if (slv_b_ready[p]) begin
          slv_b_valid[p] <= 1'b0;
        end
        if (ret_valid && (ret_port == PW'(p))) begin
          slv_r_valid[p] <= 1'b1;
          slv_r_data[p]  <= ret_data;
          slv_r_resp[p]  <= ret_resp;
        end else if (slv_r_ready[p]) begin
          slv_r_valid[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge seq_clk) begin
    if (!seq_rst) begin
      rr_ptr    <= '0;
      pause_ack <= 1'b0;
    end else begin
      if (gnt_valid) rr_ptr <= (gnt_port == PW'(NUM_PORTS - 1)) ? '0 : gnt_port + 1'b1;
      pause_ack <= pause_req && !(|rd_pend) && !(|slv_b_valid) && !(|slv_r_valid);
    end
  end

endmodule

// File: tb/tb_adam_axil_ram_mp.sv
// Directed bench for adam_axil_ram_mp: a 2-port READ_LATENCY=1 instance for the main
// scenarios and a 1-port READ_LATENCY=2 instance for the read-latency/stall scenario.
module tb_adam_axil_ram_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pause_req, pause_ack;
  logic [1:0] aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [1:0] ar_valid, ar_ready, r_valid, r_ready;
  logic [1:0][31:0] aw_addr, w_data, ar_addr, r_data;
  logic [1:0][3:0]  w_strb;
  logic [1:0][1:0]  b_resp, r_resp;

  logic d2_pause_ack;
  logic [0:0] d2_aw_valid, d2_aw_ready, d2_w_valid, d2_w_ready, d2_b_valid, d2_b_ready;
  logic [0:0] d2_ar_valid, d2_ar_ready, d2_r_valid, d2_r_ready;
  logic [0:0][31:0] d2_aw_addr, d2_w_data, d2_ar_addr, d2_r_data;
  logic [0:0][3:0]  d2_w_strb;
  logic [0:0][1:0]  d2_b_resp, d2_r_resp;

  int total = 0;
  int bad = 0;

  adam_axil_ram_mp #(.NUM_PORTS(2), .READ_LATENCY(1)) u_dut (
    .seq_clk(clk), .seq_rst(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
    .slv_aw_valid(aw_valid), .slv_aw_ready(aw_ready), .slv_aw_addr(aw_addr),
    .slv_w_valid(w_valid), .slv_w_ready(w_ready), .slv_w_data(w_data), .slv_w_strb(w_strb),
    .slv_b_valid(b_valid), .slv_b_ready(b_ready), .slv_b_resp(b_resp),
    .slv_ar_valid(ar_valid), .slv_ar_ready(ar_ready), .slv_ar_addr(ar_addr),
    .slv_r_valid(r_valid), .slv_r_ready(r_ready), .slv_r_data(r_data), .slv_r_resp(r_resp));

  adam_axil_ram_mp #(.NUM_PORTS(1), .READ_LATENCY(2)) u_dut2 (
    .seq_clk(clk), .seq_rst(rst_n), .pause_req(1'b0), .pause_ack(d2_pause_ack),
    .slv_aw_valid(d2_aw_valid), .slv_aw_ready(d2_aw_ready), .slv_aw_addr(d2_aw_addr),
    .slv_w_valid(d2_w_valid), .slv_w_ready(d2_w_ready), .slv_w_data(d2_w_data), .slv_w_strb(d2_w_strb),
    .slv_b_valid(d2_b_valid), .slv_b_ready(d2_b_ready), .slv_b_resp(d2_b_resp),
    .slv_ar_valid(d2_ar_valid), .slv_ar_ready(d2_ar_ready), .slv_ar_addr(d2_ar_addr),
    .slv_r_valid(d2_r_valid), .slv_r_ready(d2_r_ready), .slv_r_data(d2_r_data), .slv_r_resp(d2_r_resp));

  task automatic axi_write(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat, output bit to);
    int n;
    n = 0;
    @(negedge clk);
    aw_valid[p] = 1'b1; w_valid[p] = 1'b1; aw_addr[p] = a; w_data[p] = d; w_strb[p] = s;
    #1;
    while (!aw_ready[p] && n < 20) begin @(negedge clk); #1; n++; end
    to = (n >= 20);
    @(negedge clk);
    aw_valid[p] = 1'b0; w_valid[p] = 1'b0;
    lat = 1;
    while (!b_valid[p] && lat < 20) begin @(negedge clk); lat++; end
    resp = b_resp[p];
    b_ready[p] = 1'b1;
    @(negedge clk);
    b_ready[p] = 1'b0;
  endtask

  task automatic axi_read(input int p, input logic [31:0] a,
                          output logic [31:0] data, output logic [1:0] resp, output int lat, output bit to);
    int n;
    n = 0;
    @(negedge clk);
    ar_valid[p] = 1'b1; ar_addr[p] = a;
    #1;
    while (!ar_ready[p] && n < 20) begin @(negedge clk); #1; n++; end
    to = (n >= 20);
    @(negedge clk);
    ar_valid[p] = 1'b0;
    lat = 1;
    while (!r_valid[p] && lat < 20) begin @(negedge clk); lat++; end
    data = r_data[p]; resp = r_resp[p];
    r_ready[p] = 1'b1;
    @(negedge clk);
    r_ready[p] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    aw_valid[0] = 1'b1; w_valid[0] = 1'b1; ar_valid[1] = 1'b1;
    #1;
    if (aw_ready !== 2'b00) begin bad++; $display("FAIL rst_aw_ready: got %b want 00", aw_ready); end total++;
    if (ar_ready !== 2'b00) begin bad++; $display("FAIL rst_ar_ready: got %b want 00", ar_ready); end total++;
    if (b_valid !== 2'b00 || r_valid !== 2'b00) begin bad++; $display("FAIL rst_valids: got b=%b r=%b want 00", b_valid, r_valid); end total++;
    if (r_data[0] !== 32'h0 || b_resp !== 4'h0 || r_resp !== 4'h0) begin bad++; $display("FAIL rst_data_resp: got d=%h b=%h r=%h want 0", r_data[0], b_resp, r_resp); end total++;
    if (pause_ack !== 1'b0 || d2_r_valid !== 1'b0) begin bad++; $display("FAIL rst_ack: got ack=%b d2rv=%b want 0", pause_ack, d2_r_valid); end total++;
    @(negedge clk);
    aw_valid[0] = 1'b0; w_valid[0] = 1'b0; ar_valid[1] = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [31:0] d; int lat; bit to;
    axi_write(0, 32'h10, 32'hDEADBEEF, 4'hF, resp, lat, to);
    if (to || resp !== 2'b00) begin bad++; $display("FAIL basic_wr0: got to=%0d resp=%b want 0/00", to, resp); end total++;
    if (lat != 1) begin bad++; $display("FAIL basic_wr0_blat: got %0d want 1", lat); end total++;
    axi_read(0, 32'h10, d, resp, lat, to);
    if (d !== 32'hDEADBEEF || resp !== 2'b00) begin bad++; $display("FAIL basic_rd0: got %h/%b want deadbeef/00", d, resp); end total++;
    if (lat != 1 || to) begin bad++; $display("FAIL basic_rd0_rlat: got %0d want 1", lat); end total++;
    axi_write(1, 32'h10, 32'h0000AA00, 4'h2, resp, lat, to);
    if (to || resp !== 2'b00 || lat != 1) begin bad++; $display("FAIL basic_wr1: got to=%0d resp=%b lat=%0d want 0/00/1", to, resp, lat); end total++;
    axi_read(1, 32'h10, d, resp, lat, to);
    if (d !== 32'hDEADAAEF || resp !== 2'b00) begin bad++; $display("FAIL basic_rd1_strb: got %h/%b want deadaaef/00", d, resp); end total++;
    axi_read(0, 32'h13, d, resp, lat, to);
    if (d !== 32'hDEADAAEF) begin bad++; $display("FAIL basic_align: got %h want deadaaef", d); end total++;
  endtask

  task automatic test_boundary();
    logic [1:0] resp; logic [31:0] d; int lat; bit to;
    axi_write(0, 32'h0, 32'h11223344, 4'hF, resp, lat, to);
    axi_write(1, 32'hFFC, 32'h12345678, 4'hF, resp, lat, to);
    if (resp !== 2'b00) begin bad++; $display("FAIL bnd_wr_last: got %b want 00", resp); end total++;
    axi_read(1, 32'hFFC, d, resp, lat, to);
    if (d !== 32'h12345678 || resp !== 2'b00) begin bad++; $display("FAIL bnd_rd_last: got %h/%b want 12345678/00", d, resp); end total++;
    axi_read(0, 32'h1000, d, resp, lat, to);
    if (d !== 32'h0 || resp !== 2'b11) begin bad++; $display("FAIL bnd_rd_size: got %h/%b want 0/11", d, resp); end total++;
    axi_write(0, 32'h1000, 32'hFFFFFFFF, 4'hF, resp, lat, to);
    if (resp !== 2'b11) begin bad++; $display("FAIL bnd_wr_size: got %b want 11", resp); end total++;
    axi_read(0, 32'h0, d, resp, lat, to);
    if (d !== 32'h11223344) begin bad++; $display("FAIL bnd_no_alias: got %h want 11223344", d); end total++;
    axi_read(1, 32'hFFFFFFFC, d, resp, lat, to);
    if (d !== 32'h0 || resp !== 2'b11) begin bad++; $display("FAIL bnd_rd_top: got %h/%b want 0/11", d, resp); end total++;
  endtask

  task automatic test_priority();
    @(negedge clk);
    aw_valid[0] = 1'b1; w_valid[0] = 1'b1; aw_addr[0] = 32'h30; w_data[0] = 32'h55AA55AA; w_strb[0] = 4'hF;
    ar_valid[0] = 1'b1; ar_addr[0] = 32'h30;
    #1;
    if (aw_ready[0] !== 1'b1 || ar_ready[0] !== 1'b0) begin bad++; $display("FAIL prio_wr_first: got aw=%b ar=%b want 1/0", aw_ready[0], ar_ready[0]); end total++;
    @(negedge clk);
    aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
    #1;
    if (ar_ready[0] !== 1'b1 || b_valid[0] !== 1'b1) begin bad++; $display("FAIL prio_rd_next: got ar=%b bv=%b want 1/1", ar_ready[0], b_valid[0]); end total++;
    @(negedge clk);
    ar_valid[0] = 1'b0;
    if (r_valid[0] !== 1'b1 || r_data[0] !== 32'h55AA55AA) begin bad++; $display("FAIL prio_raw: got rv=%b d=%h want 1/55aa55aa", r_valid[0], r_data[0]); end total++;
    b_ready[0] = 1'b1; r_ready[0] = 1'b1;
    @(negedge clk);
    b_ready[0] = 1'b0; r_ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] prev; logic [1:0] resp; logic [31:0] d; int lat; bit to;
    @(negedge clk);
    aw_valid = 2'b11; w_valid = 2'b11; b_ready = 2'b11; w_strb = '{4'hF, 4'hF};
    aw_addr[0] = 32'h100; w_data[0] = 32'hA0A0A0A0;
    aw_addr[1] = 32'h104; w_data[1] = 32'hB0B0B0B0;
    prev = 2'b00;
    for (int i = 0; i < 8; i++) begin
      #1;
      if ($countones(aw_ready) != 1 || w_ready !== aw_ready) begin bad++; $display("FAIL b2b_onehot[%0d]: got aw=%b w=%b want one-hot equal", i, aw_ready, w_ready); end total++;
      if (i > 0) begin
        if (aw_ready !== ~prev) begin bad++; $display("FAIL b2b_alternate[%0d]: got %b want %b", i, aw_ready, ~prev); end total++;
      end
      prev = aw_ready;
      @(negedge clk);
    end
    aw_valid = 2'b00; w_valid = 2'b00;
    @(negedge clk);
    b_ready = 2'b00;
    axi_read(0, 32'h100, d, resp, lat, to);
    if (d !== 32'hA0A0A0A0) begin bad++; $display("FAIL b2b_data0: got %h want a0a0a0a0", d); end total++;
    axi_read(1, 32'h104, d, resp, lat, to);
    if (d !== 32'hB0B0B0B0) begin bad++; $display("FAIL b2b_data1: got %h want b0b0b0b0", d); end total++;
  endtask

  task automatic test_pause();
    logic [1:0] resp; logic [31:0] d; int lat; bit to;
    @(negedge clk);
    ar_valid = 2'b11; ar_addr[0] = 32'h10; ar_addr[1] = 32'hFFC; r_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ar_valid = 2'b00;
    if (r_valid !== 2'b11) begin bad++; $display("FAIL pause_two_reads: got %b want 11", r_valid); end total++;
    pause_req = 1'b1;
    aw_valid[0] = 1'b1; w_valid[0] = 1'b1; aw_addr[0] = 32'h50; w_data[0] = 32'h00000077; w_strb[0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (aw_ready !== 2'b00 || pause_ack !== 1'b0) begin bad++; $display("FAIL pause_block[%0d]: got aw=%b ack=%b want 00/0", i, aw_ready, pause_ack); end total++;
      @(negedge clk);
    end
    r_ready[0] = 1'b1;
    @(negedge clk);
    r_ready[0] = 1'b0;
    #1;
    if (pause_ack !== 1'b0 || aw_ready !== 2'b00) begin bad++; $display("FAIL pause_one_left: got ack=%b aw=%b want 0/00", pause_ack, aw_ready); end total++;
    @(negedge clk);
    r_ready[1] = 1'b1;
    @(negedge clk);
    r_ready[1] = 1'b0;
    if (pause_ack !== 1'b0) begin bad++; $display("FAIL pause_ack_early: got %b want 0", pause_ack); end total++;
    @(negedge clk);
    if (pause_ack !== 1'b1 || aw_ready !== 2'b00) begin bad++; $display("FAIL pause_ack_set: got ack=%b aw=%b want 1/00", pause_ack, aw_ready); end total++;
    pause_req = 1'b0;
    #1;
    if (aw_ready[0] !== 1'b1) begin bad++; $display("FAIL pause_resume: got %b want 1", aw_ready[0]); end total++;
    @(negedge clk);
    aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
    if (pause_ack !== 1'b0 || b_valid[0] !== 1'b1) begin bad++; $display("FAIL pause_ack_drop: got ack=%b bv=%b want 0/1", pause_ack, b_valid[0]); end total++;
    b_ready[0] = 1'b1;
    @(negedge clk);
    b_ready[0] = 1'b0;
    axi_read(1, 32'h50, d, resp, lat, to);
    if (d !== 32'h00000077) begin bad++; $display("FAIL pause_wr_data: got %h want 00000077", d); end total++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] d; int lat; bit to;
    @(negedge clk);
    aw_valid[0] = 1'b1; w_valid[0] = 1'b1; aw_addr[0] = 32'h20; w_data[0] = 32'hA5A5A5A5; w_strb[0] = 4'hF;
    ar_valid[1] = 1'b1; ar_addr[1] = 32'h10;
    @(negedge clk);
    @(negedge clk);
    aw_valid[0] = 1'b0; w_valid[0] = 1'b0; ar_valid[1] = 1'b0;
    if (b_valid[0] !== 1'b1 || r_valid[1] !== 1'b1) begin bad++; $display("FAIL rmid_pending: got bv=%b rv=%b want 1/1", b_valid[0], r_valid[1]); end total++;
    rst_n = 1'b0;
    @(negedge clk);
    if (b_valid !== 2'b00 || r_valid !== 2'b00 || pause_ack !== 1'b0) begin bad++; $display("FAIL rmid_cleared: got bv=%b rv=%b ack=%b want 00/00/0", b_valid, r_valid, pause_ack); end total++;
    rst_n = 1'b1;
    axi_read(0, 32'h20, d, resp, lat, to);
    if (d !== 32'hA5A5A5A5 || to) begin bad++; $display("FAIL rmid_data_kept: got %h want a5a5a5a5", d); end total++;
    axi_read(1, 32'h10, d, resp, lat, to);
    if (d !== 32'hDEADAAEF) begin bad++; $display("FAIL rmid_old_data: got %h want deadaaef", d); end total++;
  endtask

  task automatic test_latency2();
    @(negedge clk);
    d2_aw_valid = 1'b1; d2_w_valid = 1'b1; d2_aw_addr[0] = 32'h40; d2_w_data[0] = 32'hCAFEF00D; d2_w_strb[0] = 4'hF;
    #1;
    if (d2_aw_ready !== 1'b1) begin bad++; $display("FAIL lat2_wr: got %b want 1", d2_aw_ready); end total++;
    @(negedge clk);
    d2_aw_addr[0] = 32'h44; d2_w_data[0] = 32'h0BADBEEF; d2_b_ready = 1'b1;
    @(negedge clk);
    d2_aw_valid = 1'b0; d2_w_valid = 1'b0;
    @(negedge clk);
    d2_b_ready = 1'b0;
    d2_ar_valid = 1'b1; d2_ar_addr[0] = 32'h40;
    #1;
    if (d2_ar_ready !== 1'b1) begin bad++; $display("FAIL lat2_grant: got %b want 1", d2_ar_ready); end total++;
    @(negedge clk);
    d2_ar_addr[0] = 32'h44;
    #1;
    if (d2_r_valid !== 1'b0 || d2_ar_ready !== 1'b0) begin bad++; $display("FAIL lat2_t1: got rv=%b ar=%b want 0/0", d2_r_valid, d2_ar_ready); end total++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (d2_r_valid !== 1'b1 || d2_r_data[0] !== 32'hCAFEF00D || d2_ar_ready !== 1'b0) begin bad++; $display("FAIL lat2_stall[%0d]: got rv=%b d=%h ar=%b want 1/cafef00d/0", i, d2_r_valid, d2_r_data[0], d2_ar_ready); end total++;
    end
    @(negedge clk);
    d2_r_ready = 1'b1;
    #1;
    if (d2_ar_ready !== 1'b1) begin bad++; $display("FAIL lat2_accept_grant: got %b want 1", d2_ar_ready); end total++;
    @(negedge clk);
    d2_r_ready = 1'b0; d2_ar_valid = 1'b0;
    if (d2_r_valid !== 1'b0) begin bad++; $display("FAIL lat2_gap: got %b want 0", d2_r_valid); end total++;
    @(negedge clk);
    if (d2_r_valid !== 1'b1 || d2_r_data[0] !== 32'h0BADBEEF || d2_r_resp[0] !== 2'b00) begin bad++; $display("FAIL lat2_second: got rv=%b d=%h resp=%b want 1/0badbeef/00", d2_r_valid, d2_r_data[0], d2_r_resp[0]); end total++;
    d2_r_ready = 1'b1;
    @(negedge clk);
    d2_r_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pause_req = 1'b0;
    aw_valid = '0; w_valid = '0; b_ready = '0; ar_valid = '0; r_ready = '0;
    aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
    d2_aw_valid = '0; d2_w_valid = '0; d2_b_ready = '0; d2_ar_valid = '0; d2_r_ready = '0;
    d2_aw_addr = '0; d2_w_data = '0; d2_w_strb = '0; d2_ar_addr = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_boundary();
    test_priority();
    test_back_to_back();
    test_pause();
    test_reset_mid();
    test_latency2();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog");
  end

endmodule
